// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and default buffer depth, common to the
// receiver, transmitter and byte FIFO.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  function automatic int unsigned uart_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte storage for the UART FIFO: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module uart_fifo_ram #(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO between UART receiver and transmitter.
// Define UART_FIFO_STATS_EN to add the saturating drop_count output.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = UART_FIFO_DEPTH,
  parameter  int unsigned DATA_W = UART_DATA_W,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow
`ifdef UART_FIFO_STATS_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_full;
  logic w_nonempty;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_we;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nonempty = (r_count != '0);
  // Pop needs a stored byte, so a push into an empty FIFO never pops that cycle.
  assign w_pop      = w_nonempty && out_ready;
  assign w_push     = in_valid && (!w_full || w_pop);
  assign w_drop     = in_valid && w_full && !w_pop;
  assign w_we       = w_push && !flush;

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef UART_FIFO_STATS_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else if (flush) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign count     = r_count;
  assign out_valid = w_nonempty;
  assign empty     = !w_nonempty;
  assign full      = w_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench for uart_byte_fifo: queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_uart_byte_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          flush;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
`ifdef UART_FIFO_STATS_EN
  logic [15:0]   drop_count;
`endif

  uart_byte_fifo #(
    .DEPTH  (16),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
`ifdef UART_FIFO_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain byte queue plus sticky drop state.
  logic [7:0] q[$];
  bit         m_ovf   = 1'b0;
  int         m_drops = 0;
  bit         m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else if (flush) begin
      q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      m_pop = (q.size() != 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (in_valid) begin
        if (q.size() < DEPTH) begin
          q.push_back(in_data);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("count", 32'(count), 32'(q.size()));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
`ifdef UART_FIFO_STATS_EN
      check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Single byte, held while the transmitter is not ready.
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    check("one_valid", 32'(out_valid), 1);
    check("one_data", 32'(out_data), 32'h41);
    check("one_count", 32'(count), 1);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("one_hold", 32'(out_data), 32'h41);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("one_drained", 32'(empty), 1);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_count_held", 32'(count), 16);
`ifdef UART_FIFO_STATS_EN
    check("drop_count_one", 32'(drop_count), 1);
`endif
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 32'(out_data), 32'(i + 1));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(empty), 1);

    // Push into full FIFO with same-cycle pop.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    check("pp_count", 32'(count), 16);
    check("pp_full", 32'(full), 1);
    for (int i = 0; i < 16; i++) begin
      check("pp_drain", 32'(out_data), (i < 15) ? 32'(i + 2) : 32'h55);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("pp_empty", 32'(empty), 1);

    // Streaming with continuous ready: pointers wrap, occupancy stays <= 1.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      check("stream_count_le1", 32'(count <= 1), 1);
    end
    check("stream_tail", 32'(out_data), 32'hA7);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("stream_empty", 32'(empty), 1);

    // Flush clears contents and overflow, ignoring same-cycle push/pop.
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    check("pre_flush_ovf", 32'(overflow), 1);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    check("flush_count", 32'(count), 0);
    check("flush_ovf", 32'(overflow), 0);
    check("flush_empty", 32'(empty), 1);
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    check("post_flush_data", 32'(out_data), 32'h99);
    check("post_flush_count", 32'(count), 1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 1);
    check("arst_count", 32'(count), 0);
    check("arst_valid", 32'(out_valid), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_rst_data", 32'(out_data), 32'h3C);
    check("post_rst_count", 32'(count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("final_empty", 32'(empty), 1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
